// File: rtl/sr_ff_driver.sv
// rtl/sr_ff_driver.sv - drives legal S/R excitation to an SR flip-flop and checks its Q feedback
module sr_ff_driver #(
  parameter int unsigned CNT_W  = 8,
  parameter logic        INIT_Q = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tgt_valid,
  input  logic             i_tgt_bit,
  output logic             o_tgt_ready,
  output logic             o_s_out,
  output logic             o_r_out,
  input  logic             i_q_fb,
  output logic             o_cur_q,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_tgt;
  logic             r_s;
  logic             r_r;
  logic             r_cur_q;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_accept;

  // A target is only taken in IDLE; ready is masked while reset is asserted.
  assign o_tgt_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_tgt_valid && o_tgt_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one drive cycle, one settle cycle, then back to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_DRIVE;
      ST_DRIVE: w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: latch target, pulse excitation for one cycle, check and resync on Q feedback.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt     <= 1'b0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_cur_q   <= INIT_Q;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt <= i_tgt_bit;
            // Set only when going 0->1, reset only when going 1->0; S=R=1 cannot arise.
            r_s   <= i_tgt_bit & ~r_cur_q;
            r_r   <= ~i_tgt_bit & r_cur_q;
          end
        end
        ST_DRIVE: begin
          r_s <= 1'b0;
          r_r <= 1'b0;
        end
        ST_WAIT: begin
          r_cur_q <= i_q_fb;
          if (i_q_fb != r_tgt) begin
            r_err <= 1'b1;
            if (r_err_cnt != {CNT_W{1'b1}}) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_s <= 1'b0;
          r_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_out   = r_s;
  assign o_r_out   = r_r;
  assign o_cur_q   = r_cur_q;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sr_ff_driver.sv
// tb/tb_sr_ff_driver.sv - randomized self-checking bench for sr_ff_driver with an attached SR flip-flop model
module tb_sr_ff_driver;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tgt_valid = 1'b0;
  logic             tgt_bit = 1'b0;
  logic             tgt_ready;
  logic             s_out;
  logic             r_out;
  logic             q_fb;
  logic             cur_q;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  // Environment: external SR flip-flop plus an optional stuck-at override on its Q.
  logic ff_q = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model state (transaction level).
  int exp_cur_q;
  int exp_cnt;
  int exp_ff;

  sr_ff_driver #(.CNT_W(CNT_W), .INIT_Q(1'b0)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tgt_valid (tgt_valid),
    .i_tgt_bit   (tgt_bit),
    .o_tgt_ready (tgt_ready),
    .o_s_out     (s_out),
    .o_r_out     (r_out),
    .i_q_fb      (q_fb),
    .o_cur_q     (cur_q),
    .o_busy      (busy),
    .o_err       (err),
    .o_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_out && !r_out) ff_q <= 1'b1;
    else if (r_out && !s_out) ff_q <= 1'b0;
  end

  assign q_fb = force_en ? force_val : ff_q;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Illegal S=R=1 must never appear.
  always @(negedge clk) begin
    if (s_out && r_out) check("sr_both_high", 1, 0);
  end

  task automatic model_reset();
    exp_cur_q = 0;
    exp_cnt   = 0;
  endtask

  task automatic check_idle_reset_outputs(input string tag);
    check({tag, "_s"}, int'(s_out), 0);
    check({tag, "_r"}, int'(r_out), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_cnt"}, int'(err_cnt), 0);
    check({tag, "_curq"}, int'(cur_q), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_ready_low", int'(tgt_ready), 0);
    @(posedge clk); #1;
    check("rst_ready_low2", int'(tgt_ready), 0);
    check_idle_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("rst_ready_after", int'(tgt_ready), 1);
    model_reset();
  endtask

  // Starts a transaction just after a clock edge; returns just after E0 with checks of the drive cycle.
  task automatic start_txn(input bit t, input bit fen, input bit fval, output int es, output int er);
    tgt_valid = 1'b1;
    tgt_bit   = t;
    force_en  = fen;
    force_val = fval;
    #1;
    check("ready_before_accept", int'(tgt_ready), 1);
    es = (t == 1 && exp_cur_q == 0) ? 1 : 0;
    er = (t == 0 && exp_cur_q == 1) ? 1 : 0;
    @(posedge clk); #1;
    check("drive_s", int'(s_out), es);
    check("drive_r", int'(r_out), er);
    check("drive_busy", int'(busy), 1);
    check("drive_err_clear", int'(err), 0);
    check("drive_ready", int'(tgt_ready), 0);
    // Source may keep presenting junk while busy; it must be ignored.
    tgt_valid = 1'($urandom_range(0, 1));
    tgt_bit   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_txn(input bit t, input bit fen, input bit fval);
    int es, er, qfb, exp_err;
    start_txn(t, fen, fval, es, er);
    @(posedge clk); #1;
    if (es == 1) exp_ff = 1;
    else if (er == 1) exp_ff = 0;
    check("settle_s", int'(s_out), 0);
    check("settle_r", int'(r_out), 0);
    check("settle_busy", int'(busy), 1);
    check("settle_ready", int'(tgt_ready), 0);
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    qfb = fen ? int'(fval) : exp_ff;
    exp_err = (qfb != int'(t)) ? 1 : 0;
    if (exp_err == 1 && exp_cnt < int'(CNT_MAX)) exp_cnt++;
    exp_cur_q = qfb;
    check("done_err", int'(err), exp_err);
    check("done_cnt", int'(err_cnt), exp_cnt);
    check("done_curq", int'(cur_q), exp_cur_q);
    check("done_busy", int'(busy), 0);
    check("done_ready", int'(tgt_ready), 1);
    force_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_err", int'(err), 0);
      check("idle_ready", int'(tgt_ready), 1);
      check("idle_busy", int'(busy), 0);
    end
  endtask

  task automatic mid_reset_txn(input bit t);
    int es, er;
    start_txn(t, 1'b0, 1'b0, es, er);
    rst = 1'b1;
    @(posedge clk); #1;
    if (es == 1) exp_ff = 1;
    else if (er == 1) exp_ff = 0;
    check_idle_reset_outputs("midrst");
    check("midrst_ready", int'(tgt_ready), 0);
    model_reset();
    rst = 1'b0;
    tgt_valid = 1'b0;
    #1;
    check("midrst_ready_after", int'(tgt_ready), 1);
    @(posedge clk); #1;
    check("midrst_err_quiet", int'(err), 0);
    check("midrst_busy", int'(busy), 0);
  endtask

  initial begin
    exp_ff = 0;
    model_reset();
    #1;
    do_reset();

    // Set then reset through the real flip-flop model.
    do_txn(1'b1, 1'b0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b0);

    // Back-to-back including hold transactions.
    do_txn(1'b1, 1'b0, 1'b0);
    do_txn(1'b1, 1'b0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Single mismatch.
    do_txn(1'b1, 1'b1, 1'b0);
    idle_cycles(1);

    // Saturation: five forced mismatches from a clean count.
    do_reset();
    for (int k = 0; k < 5; k++) do_txn(1'b1, 1'b1, 1'b0);
    idle_cycles(1);

    // Reset in the drive cycle.
    mid_reset_txn(1'b1);

    // Randomized traffic with occasional stuck Q and mid-transaction resets.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        mid_reset_txn(1'($urandom_range(0, 1)));
      end else begin
        do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
      end
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_ff_driver.md
# sr_ff_driver

Stimulus-side companion for the SR flip-flop: accepts a stream of target output bits over a valid/ready handshake, converts each into the legal S/R excitation pair, drives it into an external SR flip-flop, then checks the flip-flop's Q feedback against the target. It tracks the believed flip-flop state, flags mismatches, and counts errors. It sits between a pattern source and an SR_FF instance and never issues the illegal S=R=1 combination.

## Interface
- CNT_W, 8: width of the saturating error counter.
- INIT_Q, 1'b0: value of cur_q after reset.

- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target bit present.
- tgt_bit  input  1  desired Q of the flip-flop.
- tgt_ready  output  1  block can accept a target this cycle.
- s_out  output  1  S drive to the flip-flop (registered).
- r_out  output  1  R drive to the flip-flop (registered).
- q_fb  input  1  Q returned from the flip-flop.
- cur_q  output  1  block's tracked flip-flop state.
- busy  output  1  transaction in progress (state != IDLE).
- err  output  1  one-cycle pulse on Q mismatch.
- err_cnt  output  CNT_W  mismatch count, saturating.

## Operation
- States: IDLE, DRIVE, WAIT.
- Accept: handshake occurs on a clock edge where tgt_valid && tgt_ready. tgt_ready = (state==IDLE) && !rst. tgt_bit is latched into an internal target register.
- Excitation from latched target t and cur_q:
  - t==cur_q: S=0, R=0 (hold).
  - t=1, cur_q=0: S=1, R=0.
  - t=0, cur_q=1: S=0, R=1.
  - S=R=1 is never produced in any state.
- IDLE -> DRIVE on accept; s_out/r_out load the excitation.
- DRIVE -> WAIT unconditionally; s_out/r_out return to 0.
- WAIT -> IDLE unconditionally. At this edge q_fb is compared with target: on mismatch err=1 for one cycle and err_cnt increments, holding at 2^CNT_W-1. In every case cur_q <= q_fb (resynchronises to the real flip-flop).
- Hold transactions (S=R=0) still run the full DRIVE/WAIT sequence and are checked.
- tgt_valid while busy is ignored; the source holds it until tgt_ready.
- Reset (any state, including mid-transaction): at the next edge state=IDLE, s_out=0, r_out=0, err=0, err_cnt=0, cur_q=INIT_Q, target discarded, no err pulse.

## Timing
- Reset values: s_out=0, r_out=0, err=0, err_cnt=0, cur_q=INIT_Q, busy=0, tgt_ready=0 while rst=1 and 1 in the first cycle after rst falls.
- Accept edge E0 -> s_out/r_out valid E0..E1 (exactly one cycle); flip-flop samples them at E1.
- q_fb sampled at E2; err, err_cnt, cur_q updated after E2; tgt_ready=1 after E2.
- Throughput: one target per 3 cycles with tgt_valid held high; next accept earliest at E3.
- busy = 1 from after E0 to E2.
- err_cnt saturates; it does not wrap.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 -> s_out=r_out=0, err=0, err_cnt=0, cur_q=0; tgt_ready=0 during reset, 1 after.
- Set then reset with a model SR_FF attached: targets 1, then 0 -> first s_out=1,r_out=0 for one cycle, cur_q=1 after E2; second r_out=1,s_out=0 for one cycle, cur_q=0; err never asserted.
- Hold and back-to-back: tgt_valid held high, bits 1,1,0,0 -> accepts every 3 cycles; repeats drive s_out=r_out=0; s_out&r_out never 1; err=0.
- Mismatch: q_fb forced 0, target 1 -> s_out=1 one cycle, err pulses one cycle after E2, err_cnt=1, cur_q=0.
- Saturation: CNT_W=2, q_fb stuck 0, five targets of 1 -> err pulses five times, err_cnt 1,2,3,3,3.
- Reset mid-transaction: rst=1 at E1 (DRIVE) -> next cycle s_out=r_out=0, busy=0, no err pulse, err_cnt=0, cur_q=INIT_Q.
